// File: rtl/irb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irb_pkg
//  Description : Shared defaults and drain-FSM state type for the
//                accumulation buffer (fmo_acc_buffer) and its lane adders.
//  Contents    : PX_W        - default per-lane width (signed)
//                FMO_N_ELEM  - default words per lane
//                FMO_LANES   - default lanes per word
//                drain_state_t - IDLE / DRAIN / LAST
//  Revision    : 1.0 - initial release
// ============================================================================
package irb_pkg;

    localparam int PX_W       = 8;
    localparam int FMO_N_ELEM = 8;
    localparam int FMO_LANES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LAST  = 2'd2
    } drain_state_t;

endpackage : irb_pkg
`default_nettype wire

// File: rtl/fmo_acc_buffer_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : sat_add
//  Description : Signed two's-complement adder that clamps to the
//                representable range instead of wrapping.
//  Ports       : a, b - signed operands (DATA_W)
//                y    - saturated sum   (DATA_W)
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_add #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    localparam logic [DATA_W-1:0] c_max = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_min = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] w_sum;

    always_comb begin
        // One guard bit: the top two bits differ exactly on overflow,
        // and the guard bit then carries the true sign of the result.
        w_sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
            y = w_sum[DATA_W] ? c_min : c_max;
        end else begin
            y = w_sum[DATA_W-1:0];
        end
    end

endmodule : sat_add
`default_nettype wire

// File: rtl/fmo_acc_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fmo_acc_buffer
//  Description : Lane-packed partial-sum tile buffer. Supports overwrite and
//                saturating accumulate (2-stage read-modify-write with
//                forwarding), a 1-cycle write-first random read port, and a
//                ready/valid drain that streams every word in order and
//                clears each word once it has been accepted.
//  Ports       : clk, reset (sync, active high)
//                acc_mode, wr_en, wr_addr, wr_data   - write / accumulate
//                rd_en, rd_addr, rd_data             - random read
//                drain_start, drain_valid, drain_ready,
//                drain_data, drain_done, busy        - tile drain
//  Revision    : 1.0 - initial release
// ============================================================================
module fmo_acc_buffer
    import irb_pkg::*;
#(
    parameter int DATA_W = PX_W,
    parameter int DEPTH  = FMO_N_ELEM,
    parameter int LANES  = FMO_LANES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      acc_mode,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [LANES*DATA_W-1:0]   wr_data,
    input  logic                      rd_en,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [LANES*DATA_W-1:0]   rd_data,
    input  logic                      drain_start,
    output logic                      drain_valid,
    input  logic                      drain_ready,
    output logic [LANES*DATA_W-1:0]   drain_data,
    output logic                      drain_done,
    output logic                      busy
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_word_w = LANES * DATA_W;

    logic [c_word_w-1:0] r_mem [DEPTH];

    drain_state_t        r_state;
    logic                r_start_pend;
    logic [c_addr_w-1:0] r_drain_addr;

    // Accumulate stage 2: operands captured in stage 1, sum written here.
    logic                r_s2_valid;
    logic [c_addr_w-1:0] r_s2_addr;
    logic [c_word_w-1:0] r_s2_old;
    logic [c_word_w-1:0] r_s2_add;
    logic [c_word_w-1:0] w_s2_sum;

    logic                w_idle;
    logic                w_wr_addr_ok;
    logic                w_rd_addr_ok;
    logic                w_start_req;
    logic                w_start_go;
    logic                w_ow;
    logic                w_acc;
    logic                w_rd;
    logic                w_drain_acc;
    logic [c_addr_w-1:0] w_drain_next_addr;
    logic [c_word_w-1:0] w_acc_view;
    logic [c_word_w-1:0] w_rd_view;
    logic [c_word_w-1:0] w_d0_view;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_wr_addr_ok = (32'(wr_addr) < DEPTH);
    assign w_rd_addr_ok = (32'(rd_addr) < DEPTH);

    // A drain request waits while an accumulate is in stage 2. New
    // accumulates are held off while the request is outstanding so the
    // pipeline is guaranteed empty one cycle later and the drain never
    // races a late read-modify-write commit.
    assign w_start_req = w_idle && (drain_start || r_start_pend);
    assign w_start_go  = w_start_req && !r_s2_valid;

    assign w_ow  = w_idle && wr_en && !acc_mode && w_wr_addr_ok;
    assign w_acc = w_idle && wr_en &&  acc_mode && w_wr_addr_ok && !w_start_req;
    assign w_rd  = w_idle && rd_en && w_rd_addr_ok;

    assign w_drain_acc       = (r_state == ST_DRAIN) && drain_valid && drain_ready;
    assign w_drain_next_addr = r_drain_addr + 1'b1;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            sat_add #(
                .DATA_W (DATA_W)
            ) u_sat_add (
                .a (r_s2_old[i*DATA_W +: DATA_W]),
                .b (r_s2_add[i*DATA_W +: DATA_W]),
                .y (w_s2_sum[i*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Stage-1 operand: forward the sum still in flight to the same word so
    // back-to-back accumulates chain correctly.
    always_comb begin
        w_acc_view = r_mem[wr_addr];
        if (r_s2_valid && (r_s2_addr == wr_addr)) begin
            w_acc_view = w_s2_sum;
        end
    end

    // Read result reflects whatever is written at this same edge; an
    // overwrite beats a simultaneous stage-2 commit to the same word.
    always_comb begin
        w_rd_view = r_mem[rd_addr];
        if (r_s2_valid && (r_s2_addr == rd_addr)) begin
            w_rd_view = w_s2_sum;
        end
        if (w_ow && (wr_addr == rd_addr)) begin
            w_rd_view = wr_data;
        end
    end

    // First drained word, including an overwrite landing on the start edge.
    always_comb begin
        w_d0_view = r_mem[0];
        if (w_ow && (wr_addr == '0)) begin
            w_d0_view = wr_data;
        end
    end

    // Storage is deliberately not reset; writes are simply suppressed
    // during the reset cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_s2_valid) begin
                r_mem[r_s2_addr] <= w_s2_sum;
            end
            if (w_ow) begin
                r_mem[wr_addr] <= wr_data;
            end
            if (w_drain_acc) begin
                r_mem[r_drain_addr] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_start_pend <= 1'b0;
            r_drain_addr <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_addr    <= '0;
            r_s2_old     <= '0;
            r_s2_add     <= '0;
            rd_data      <= '0;
            drain_valid  <= 1'b0;
            drain_data   <= '0;
            drain_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_s2_valid <= w_acc;
            if (w_acc) begin
                r_s2_addr <= wr_addr;
                r_s2_old  <= w_acc_view;
                r_s2_add  <= wr_data;
            end

            if (w_rd) begin
                rd_data <= w_rd_view;
            end

            drain_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_start_go) begin
                        r_state      <= ST_DRAIN;
                        r_start_pend <= 1'b0;
                        r_drain_addr <= '0;
                        drain_data   <= w_d0_view;
                        drain_valid  <= 1'b1;
                        busy         <= 1'b1;
                    end else if (w_start_req) begin
                        r_start_pend <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_acc) begin
                        if (32'(r_drain_addr) == DEPTH - 1) begin
                            r_state     <= ST_LAST;
                            drain_valid <= 1'b0;
                            drain_done  <= 1'b1;
                        end else begin
                            r_drain_addr <= w_drain_next_addr;
                            drain_data   <= r_mem[w_drain_next_addr];
                        end
                    end
                end
                ST_LAST: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : fmo_acc_buffer
`default_nettype wire

// File: tb/tb_fmo_acc_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fmo_acc_buffer
//  Description : Self-checking bench for fmo_acc_buffer (DATA_W=8, DEPTH=8,
//                LANES=4). A lane-level integer model of the tile is kept in
//                an array and updated with plain clamped arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fmo_acc_buffer;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int LN = 4;
    localparam int AW = 3;
    localparam int WW = LN * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          acc_mode = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [WW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [WW-1:0] rd_data;
    logic          drain_start = 1'b0;
    logic          drain_valid;
    logic          drain_ready = 1'b0;
    logic [WW-1:0] drain_data;
    logic          drain_done;
    logic          busy;

    always #5 clk = ~clk;

    fmo_acc_buffer #(
        .DATA_W (DW),
        .DEPTH  (DP),
        .LANES  (LN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .acc_mode    (acc_mode),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .drain_start (drain_start),
        .drain_valid (drain_valid),
        .drain_ready (drain_ready),
        .drain_data  (drain_data),
        .drain_done  (drain_done),
        .busy        (busy)
    );

    int            n_chk  = 0;
    int            n_pass = 0;
    int            n_fail = 0;
    int            mm [DP][LN];
    logic [WW-1:0] exp_rd = '0;

    function automatic int clamp(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic logic [WW-1:0] pack4(input int l0, input int l1,
                                            input int l2, input int l3);
        logic [WW-1:0] w;
        int            v [LN];
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        for (int l = 0; l < LN; l++) w[l*DW +: DW] = v[l][DW-1:0];
        return w;
    endfunction

    function automatic logic [WW-1:0] model_word(input int a);
        logic [WW-1:0] w;
        for (int l = 0; l < LN; l++) w[l*DW +: DW] = mm[a][l][DW-1:0];
        return w;
    endfunction

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int l = 0; l < LN; l++) w[l*DW +: DW] = DW'($urandom_range(0, 255));
        return w;
    endfunction

    task automatic model_write(input int a, input logic [WW-1:0] d, input logic acc);
        int v;
        for (int l = 0; l < LN; l++) begin
            v = $signed(d[l*DW +: DW]);
            mm[a][l] = acc ? clamp(mm[a][l] + v) : v;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int a, input logic [WW-1:0] d, input logic acc);
        wr_en    = 1'b1;
        acc_mode = acc;
        wr_addr  = a[AW-1:0];
        wr_data  = d;
        model_write(a, d, acc);
        step();
        wr_en    = 1'b0;
        acc_mode = 1'b0;
    endtask

    task automatic do_read(input string tag, input int a);
        rd_en   = 1'b1;
        rd_addr = a[AW-1:0];
        exp_rd  = model_word(a);
        step();
        rd_en   = 1'b0;
        check(tag, rd_data, exp_rd);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (drain_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (drain_valid !== 1'b1) check("drain_valid_timeout", {31'b0, drain_valid}, 1);
    endtask

    initial begin
        int            k;
        int            cyc;
        logic [WW-1:0] d;

        // ---------------- reset ----------------
        reset = 1'b1;
        step();
        step();
        check("rst_rd_data",     rd_data,     0);
        check("rst_drain_valid", {31'b0, drain_valid}, 0);
        check("rst_drain_done",  {31'b0, drain_done},  0);
        check("rst_busy",        {31'b0, busy},        0);
        check("rst_drain_data",  drain_data,  0);
        reset = 1'b0;

        for (int a = 0; a < DP; a++) do_write(a, rand_word(), 1'b0);

        // ---------------- overwrite then read ----------------
        do_write(3, pack4(1, 2, 3, 4), 1'b0);
        do_read("ow_read_addr3", 3);
        check("ow_const_addr3", rd_data, 32'h04030201);

        // ---------------- three back-to-back accumulates ----------------
        do_write(5, pack4(0, 0, 0, 0), 1'b0);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; acc_mode = 1'b1; wr_addr = 3'd5; wr_data = pack4(10, 10, 10, 10);
            model_write(5, wr_data, 1'b1);
            step();
        end
        wr_en = 1'b0; acc_mode = 1'b0;
        do_read("acc3_read", 5);
        check("acc3_const", rd_data, pack4(30, 30, 30, 30));

        // ---------------- saturation ----------------
        do_write(1, pack4(120, -120, 0, 5), 1'b0);
        do_write(1, pack4(20, -20, -3, -7), 1'b1);
        do_read("sat_read", 1);
        check("sat_const", rd_data, pack4(127, -128, -3, -2));

        // ---------------- overwrite right after accumulate ----------------
        do_write(2, pack4(1, 1, 1, 1), 1'b1);
        do_write(2, pack4(9, -9, 7, -7), 1'b0);
        do_read("ow_after_acc", 2);
        check("ow_after_acc_const", rd_data, pack4(9, -9, 7, -7));

        // ---------------- randomized mix against the model ----------------
        for (int i = 0; i < 200; i++) begin
            wr_en    = 1'($urandom_range(0, 1));
            acc_mode = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, DP - 1));
            wr_data  = rand_word();
            rd_en    = 1'($urandom_range(0, 1));
            rd_addr  = AW'($urandom_range(0, DP - 1));
            if (rd_en) begin
                if (wr_en && !acc_mode && wr_addr == rd_addr) exp_rd = wr_data;
                else exp_rd = model_word(int'(rd_addr));
            end
            if (wr_en) model_write(int'(wr_addr), wr_data, acc_mode);
            step();
            check("rand_rd", rd_data, exp_rd);
        end
        wr_en = 1'b0; rd_en = 1'b0; acc_mode = 1'b0;
        step();

        // ---------------- drain with deferred start and stalls ----------------
        do_write(0, pack4(1, 1, 1, 1), 1'b1);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        check("start_deferred", {31'b0, busy}, 0);
        wait_valid(4);
        check("drain_busy", {31'b0, busy}, 1);

        k = 0;
        cyc = 0;
        while (k < DP && cyc < 64) begin
            check("drain_valid_hi", {31'b0, drain_valid}, 1);
            check("drain_word", drain_data, model_word(k));
            check("drain_done_lo", {31'b0, drain_done}, 0);
            drain_ready = cyc[0];
            wr_en    = 1'b1;
            acc_mode = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, DP - 1));
            wr_data  = rand_word();
            rd_en    = 1'b1;
            rd_addr  = AW'($urandom_range(0, DP - 1));
            step();
            if (drain_ready) begin
                for (int l = 0; l < LN; l++) mm[k][l] = 0;
                k++;
            end
            check("rd_hold_busy", rd_data, exp_rd);
            cyc++;
        end
        wr_en = 1'b0; rd_en = 1'b0; acc_mode = 1'b0; drain_ready = 1'b0;
        check("drain_count", k, DP);
        check("done_pulse",   {31'b0, drain_done},  1);
        check("last_valid_lo", {31'b0, drain_valid}, 0);
        step();
        check("done_one_cycle", {31'b0, drain_done}, 0);
        check("idle_after_drain", {31'b0, busy}, 0);
        for (int a = 0; a < DP; a++) do_read("cleared_read", a);

        // ---------------- reset in the middle of a drain ----------------
        for (int a = 0; a < DP; a++) do_write(a, rand_word(), 1'b0);
        drain_ready = 1'b1;
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        wait_valid(4);
        k = 0;
        while (k < 3) begin
            check("drain2_word", drain_data, model_word(k));
            step();
            for (int l = 0; l < LN; l++) mm[k][l] = 0;
            k++;
        end
        check("drain2_word3", drain_data, model_word(3));
        reset = 1'b1;
        step();
        reset = 1'b0;
        drain_ready = 1'b0;
        exp_rd = '0;
        check("rst_mid_busy",  {31'b0, busy},        0);
        check("rst_mid_valid", {31'b0, drain_valid}, 0);
        check("rst_mid_done",  {31'b0, drain_done},  0);
        check("rst_mid_rd",    rd_data, exp_rd);
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_done_after_rst", {31'b0, drain_done}, 0);
        end
        for (int a = 0; a < DP; a++) do_read("after_rst_read", a);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_fmo_acc_buffer
`default_nettype wire

// File: doc/fmo_acc_buffer.md
FMO_ACC_BUFFER -- requirements
Module: fmo_acc_buffer

Interface
REQ-001 The module SHALL have parameter DATA_W, default PX_W, meaning per-lane pixel/partial-sum width (signed two's complement).
REQ-002 The module SHALL have parameter DEPTH, default FMO_N_ELEM, meaning words per lane.
REQ-003 The module SHALL have parameter LANES, default 4, meaning parallel output channels stored per word.
REQ-004 One clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 acc_mode  in  1  0 = overwrite, 1 = accumulate into stored value.
REQ-007 wr_en  in  1  write/accumulate request.
REQ-008 wr_addr  in  $clog2(DEPTH)  target word.
REQ-009 wr_data  in  LANES*DATA_W  lane-packed data, lane 0 in the LSBs.
REQ-010 rd_en  in  1  random read request.
REQ-011 rd_addr  in  $clog2(DEPTH)  read word.
REQ-012 rd_data  out  LANES*DATA_W  random-read result.
REQ-013 drain_start  in  1  one-cycle pulse starting a full-tile drain.
REQ-014 drain_valid  out  1  drain_data valid.
REQ-015 drain_ready  in  1  downstream accepts drain_data.
REQ-016 drain_data  out  LANES*DATA_W  drained word.
REQ-017 drain_done  out  1  one-cycle pulse after the last word is accepted.
REQ-018 busy  out  1  high while draining.

Function
REQ-019 Overwrite (acc_mode=0): mem[wr_addr] <= wr_data at the edge where wr_en=1.
REQ-020 Accumulate (acc_mode=1): two-stage read-modify-write; stage 1 reads mem[wr_addr], stage 2 writes per-lane saturating sum; new value visible one cycle later than overwrite.
REQ-021 Saturation: per lane, results above 2^(DATA_W-1)-1 clamp to that value, below -2^(DATA_W-1) clamp to that value; no wrap-around.
REQ-022 Hazard: an accumulate to the address currently in stage 2 SHALL use the stage-2 result (forwarding), so back-to-back accumulates to one address sum correctly every cycle.
REQ-023 Overwrite following an accumulate to the same address in the previous cycle: the overwrite wins (final value = overwrite data).
REQ-024 Random read latency 1 cycle; rd_data holds until the next rd_en; write-first: a read matching a write committed in the same cycle returns the committed value.
REQ-025 Drain FSM states IDLE, DRAIN, LAST; IDLE->DRAIN on drain_start when no accumulate is in stage 2, otherwise start deferred one cycle.
REQ-026 DRAIN presents words 0..DEPTH-1 in order; address advances only on drain_valid && drain_ready; drain_data stable while drain_valid && !drain_ready.
REQ-027 Each accepted drained word SHALL be cleared to zero (tile ready for next accumulation).
REQ-028 Acceptance of word DEPTH-1 -> LAST; LAST pulses drain_done one cycle -> IDLE.
REQ-029 While busy, wr_en and rd_en SHALL be ignored (no memory change, rd_data unchanged); drain_start while busy ignored.
REQ-030 Address inputs >= DEPTH SHALL be ignored (no write, rd_data unchanged).

Reset
REQ-031 Reset SHALL return FSM to IDLE, clear the accumulate pipeline, drain_valid=0, drain_done=0, busy=0, rd_data=0, drain_data=0.
REQ-032 Reset SHALL NOT clear memory contents; reset mid-drain abandons the drain with no done pulse.

Structure
REQ-033 DATA_W/DEPTH/LANES defaults and the drain FSM state enum SHALL live in irb_pkg.
REQ-034 The per-lane saturating adder SHALL be one sub-module, sat_add, instantiated LANES times.

Verification
REQ-035 DATA_W=8, LANES=4: overwrite addr 3 = {1,2,3,4}, read addr 3 -> {1,2,3,4} one cycle later.
REQ-036 Accumulate {10,10,10,10} to addr 5 on three consecutive cycles from zero -> read {30,30,30,30}.
REQ-037 Stored 120, accumulate +20 -> 127; stored -120, accumulate -20 -> -128.
REQ-038 DEPTH=8 drain with drain_ready low every other cycle -> 8 words in order, each held while stalled, drain_done after word 7, then all reads = 0.
REQ-039 wr_en during drain -> no memory change; reset asserted at drain word 3 -> busy=0 next cycle, no drain_done.
